// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light controller family and its road model.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'b00,
        YELLOW  = 2'b01,
        RED     = 2'b10,
        ILLEGAL = 2'b11
    } light_t;

    typedef enum logic {
        IDLE     = 1'b0,
        CROSSING = 1'b1
    } lane_state_t;

endpackage

// File: rtl/traffic_road_model_if.sv
// Light/sensor link between a traffic_signal controller (master) and the road model (slave).
interface traffic_road_model_if;
    import traffic_pkg::*;

    light_t SA;
    light_t SB;
    logic   TA;
    logic   TB;

    modport master (output SA, output SB, input TA, input TB);
    modport slave  (input SA, input SB, output TA, output TB);

endinterface

// File: rtl/traffic_road_model_lane.sv
// One road lane: periodic/manual arrivals, saturating car queue and a crossing FSM
// that lets one car through per green-started crossing.
module road_lane
    import traffic_pkg::*;
#(
    parameter int ARR_PERIOD    = 5,
    parameter int DEPART_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  light_t           light,
    input  logic             arr_en,
    input  logic             car_in,
    output logic             sensor,
    output logic [CNT_W-1:0] cnt,
    output logic             passed,
    output logic             ovf
);

    localparam int AT_W = (ARR_PERIOD > 1) ? $clog2(ARR_PERIOD) : 1;
    localparam int DT_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [AT_W-1:0]    ARR_LAST = AT_W'(ARR_PERIOD - 1);
    localparam logic [DT_W-1:0]    DEP_LOAD = DT_W'(DEPART_CYCLES - 1);
    localparam logic [CNT_W+1:0]   CNT_MAX  = (CNT_W + 2)'((2 ** CNT_W) - 1);

    lane_state_t      state_q, state_d;
    logic [AT_W-1:0]  arr_timer_q, arr_timer_d;
    logic [DT_W-1:0]  dep_timer_q, dep_timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             passed_q, passed_d;
    logic             ovf_q, ovf_d;
    logic             periodic;
    logic             completion;
    logic [CNT_W+1:0] sum;

    always_comb begin
        periodic    = arr_en && (arr_timer_q == ARR_LAST);
        arr_timer_d = '0;
        if (arr_en && !periodic) begin
            arr_timer_d = arr_timer_q + AT_W'(1);
        end

        completion  = (state_q == CROSSING) && (dep_timer_q == '0);
        state_d     = state_q;
        dep_timer_d = dep_timer_q;
        passed_d    = 1'b0;
        // A crossing can only begin on green, but once begun it always finishes.
        case (state_q)
            IDLE: begin
                if (light == GREEN && cnt_q != '0) begin
                    state_d     = CROSSING;
                    dep_timer_d = DEP_LOAD;
                end
            end
            CROSSING: begin
                if (dep_timer_q == '0) begin
                    state_d  = IDLE;
                    passed_d = 1'b1;
                end else begin
                    dep_timer_d = dep_timer_q - DT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        sum   = {2'b00, cnt_q} + (CNT_W + 2)'(car_in) + (CNT_W + 2)'(periodic)
                - (CNT_W + 2)'(completion);
        cnt_d = sum[CNT_W-1:0];
        ovf_d = ovf_q;
        if (sum[CNT_W+1]) begin
            cnt_d = '0;
        end else if (sum > CNT_MAX) begin
            cnt_d = '1;
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            arr_timer_q <= '0;
            dep_timer_q <= '0;
            cnt_q       <= '0;
            passed_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            arr_timer_q <= arr_timer_d;
            dep_timer_q <= dep_timer_d;
            cnt_q       <= cnt_d;
            passed_q    <= passed_d;
            ovf_q       <= ovf_d;
        end
    end

    assign sensor = (cnt_q != '0);
    assign cnt    = cnt_q;
    assign passed = passed_q;
    assign ovf    = ovf_q;

endmodule

// File: rtl/traffic_road_model.sv
// Road/plant model for the traffic controller: two lanes plus a sticky monitor
// that flags conflicting greens and illegal light codes.
module traffic_road_model
    import traffic_pkg::*;
#(
    parameter int CNT_W         = 4,
    parameter int ARR_PERIOD_A  = 5,
    parameter int ARR_PERIOD_B  = 7,
    parameter int DEPART_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    traffic_road_model_if.slave   road_if,
    input  logic                  arr_en_A,
    input  logic                  arr_en_B,
    input  logic                  car_in_A,
    input  logic                  car_in_B,
    output logic [CNT_W-1:0]      cnt_A,
    output logic [CNT_W-1:0]      cnt_B,
    output logic                  passed_A,
    output logic                  passed_B,
    output logic                  ovf_A,
    output logic                  ovf_B,
    output logic                  conflict,
    output logic                  illegal
);

    logic conflict_q, conflict_d;
    logic illegal_q, illegal_d;

    road_lane #(
        .ARR_PERIOD    (ARR_PERIOD_A),
        .DEPART_CYCLES (DEPART_CYCLES),
        .CNT_W         (CNT_W)
    ) u_lane_a (
        .clk    (clk),
        .reset  (reset),
        .light  (road_if.SA),
        .arr_en (arr_en_A),
        .car_in (car_in_A),
        .sensor (road_if.TA),
        .cnt    (cnt_A),
        .passed (passed_A),
        .ovf    (ovf_A)
    );

    road_lane #(
        .ARR_PERIOD    (ARR_PERIOD_B),
        .DEPART_CYCLES (DEPART_CYCLES),
        .CNT_W         (CNT_W)
    ) u_lane_b (
        .clk    (clk),
        .reset  (reset),
        .light  (road_if.SB),
        .arr_en (arr_en_B),
        .car_in (car_in_B),
        .sensor (road_if.TB),
        .cnt    (cnt_B),
        .passed (passed_B),
        .ovf    (ovf_B)
    );

    // An illegal code is treated as not-red, so it can also raise a conflict.
    always_comb begin
        conflict_d = conflict_q | ((road_if.SA != RED) && (road_if.SB != RED));
        illegal_d  = illegal_q  | (road_if.SA == ILLEGAL) | (road_if.SB == ILLEGAL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
            illegal_q  <= illegal_d;
        end
    end

    assign conflict = conflict_q;
    assign illegal  = illegal_q;

endmodule
